// File: rtl/midi_tx.sv
// Serial MIDI transmitter: valid/ready byte FIFO feeding an 8N1, LSB-first frame shifter.
// The line idles high and every bit lasts CLK_DIV clock cycles.
module midi_tx #(
  parameter int unsigned CLK_DIV = 384,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             midi_out,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] CountFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               out_q, out_d;
  logic               push, pop, baud_zero;

  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  assign tx_ready   = (count_q != CountFull);
  assign push       = tx_valid & tx_ready;
  assign baud_zero  = (baud_q == '0);
  assign fifo_count = count_q;
  assign midi_out   = out_q;
  assign busy       = (state_q != StIdle) | (count_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_zero ? BaudMax : baud_q - BaudW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_d  = 1'b1;
        baud_d = BaudMax;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          out_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_zero) begin
          out_d   = shift_q[0];
          bit_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_zero) begin
          if (bit_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = StStop;
          end else begin
            out_d   = shift_q[1];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_zero) begin
          // Chain straight into the next start bit so frames run back-to-back.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            out_d   = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push && !pop) begin
        count_q <= count_q + (FIFO_AW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (FIFO_AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: a fast-baud instance for framing/FIFO/reset behaviour and a
// default-baud instance for bit and frame period at the pin.
module tb_midi_tx;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       midi_out, midi_out2;
  logic       busy, busy2;
  logic [2:0] fifo_count, fifo_count2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] send_q[$];
  logic [8:0] rx_q[$];

  always #5 clk = ~clk;

  midi_tx #(.CLK_DIV(D), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .midi_out(midi_out), .busy(busy), .fifo_count(fifo_count)
  );

  midi_tx dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .midi_out(midi_out2), .busy(busy2), .fifo_count(fifo_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (send_q.size() != 0) begin
      tx_valid = 1'b1;
      tx_data  = send_q[0];
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  // Advance one cycle; the sender holds each byte until it is accepted.
  task automatic step();
    logic       hs;
    logic [7:0] tmp;
    hs = tx_valid & tx_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) tmp = send_q.pop_front();
    drive();
  endtask

  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int nf, input string tag);
    logic [7:0] bs [3];
    bs[0] = b0;
    bs[1] = b1;
    bs[2] = b2;
    for (int f = 0; f < nf; f++) begin
      for (int t = 0; t < 10 * D; t++) begin
        check($sformatf("%s line f%0d t%0d", tag, f, t), midi_out, fbit(bs[f], t / D));
        check($sformatf("%s busy f%0d t%0d", tag, f, t), busy, 1);
        step();
      end
    end
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] b);
    logic [8:0] v;
    v = 'x;
    if (rx_q.size() != 0) v = rx_q.pop_front();
    check(tag, v, {1'b1, b});
  endtask

  task automatic mwait(input int n, inout logic bad);
    repeat (n) begin
      @(negedge clk);
      if (reset) bad = 1'b1;
    end
  endtask

  // Pin decoder: samples mid-bit and records {stop, data}; frames cut by reset are dropped.
  initial begin
    logic       bad;
    logic [7:0] b;
    logic       stopb;
    forever begin
      @(negedge clk);
      if (!reset && midi_out === 1'b0) begin
        bad = 1'b0;
        b   = '0;
        mwait(D + D / 2, bad);
        for (int i = 0; i < 8; i++) begin
          b[i] = midi_out;
          if (i < 7) mwait(D, bad);
        end
        mwait(D, bad);
        stopb = midi_out;
        mwait(D - D / 2 - 1, bad);
        if (!bad) rx_q.push_back({stopb, b});
      end
    end
  end

  initial begin
    int   c0;
    int   n;
    logic seen_low, seen_busy;

    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    tx_valid2 = 1'b0;
    tx_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst midi_out", midi_out, 1);
    check("rst tx_ready", tx_ready, 1);
    check("rst busy", busy, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst midi_out2", midi_out2, 1);
    check("rst tx_ready2", tx_ready2, 1);
    reset = 1'b0;
    repeat (3) step();

    // Single byte while idle
    send_q.push_back(8'h90);
    drive();
    step();
    check("t1 count k+1", fifo_count, 1);
    check("t1 busy k+1", busy, 1);
    step();
    check("t1 count k+2", fifo_count, 0);
    stream(8'h90, 8'h00, 8'h00, 1, "t1");
    check("t1 idle line", midi_out, 1);
    check("t1 busy low", busy, 0);
    rx_expect("t1 rx", 8'h90);
    repeat (3) step();

    // Three bytes on consecutive cycles go out with no gap
    send_q.push_back(8'h90);
    send_q.push_back(8'h3C);
    send_q.push_back(8'h7F);
    drive();
    step();
    check("t2 count k+1", fifo_count, 1);
    step();
    check("t2 count k+2", fifo_count, 1);
    stream(8'h90, 8'h3C, 8'h7F, 3, "t2");
    check("t2 idle line", midi_out, 1);
    check("t2 busy low", busy, 0);
    rx_expect("t2 rx0", 8'h90);
    rx_expect("t2 rx1", 8'h3C);
    rx_expect("t2 rx2", 8'h7F);
    repeat (3) step();

    // Full FIFO with valid held high, then backpressure, then refill after the first pop
    for (int i = 0; i < 6; i++) send_q.push_back(8'hA1 + 8'(i));
    drive();
    c0 = cyc;
    step();
    check("t3 count k+1", fifo_count, 1);
    repeat (4) step();
    check("t3 count k+5", fifo_count, 4);
    check("t3 ready k+5", tx_ready, 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t3 bp count %0d", i), fifo_count, 4);
      check($sformatf("t3 bp ready %0d", i), tx_ready, 0);
      step();
    end
    repeat (16) step();
    check("t3 count k+41", fifo_count, 4);
    check("t3 ready k+41", tx_ready, 0);
    step();
    check("t3 count k+42", fifo_count, 3);
    check("t3 ready k+42", tx_ready, 1);
    step();
    check("t3 count k+43", fifo_count, 4);
    check("t3 ready k+43", tx_ready, 0);
    check("t3 sender drained", send_q.size(), 0);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("t3 busy low", busy, 0);
    check("t3 duration", cyc - c0, 242);
    for (int i = 0; i < 6; i++) rx_expect($sformatf("t3 rx%0d", i), 8'hA1 + 8'(i));
    repeat (3) step();

    // Reset during data bit 3 of 0xAA with two bytes queued
    send_q.push_back(8'hAA);
    send_q.push_back(8'hB1);
    send_q.push_back(8'hB2);
    drive();
    repeat (19) step();
    check("t4 bit3 line", midi_out, 1);
    check("t4 queued", fifo_count, 2);
    check("t4 busy pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4 midi_out", midi_out, 1);
    check("t4 fifo_count", fifo_count, 0);
    check("t4 busy", busy, 0);
    check("t4 tx_ready", tx_ready, 1);
    seen_low = 1'b0;
    seen_busy = 1'b0;
    repeat (100) begin
      step();
      seen_low |= ~midi_out;
      seen_busy |= busy;
    end
    check("t4 no frame line", seen_low, 0);
    check("t4 no frame busy", seen_busy, 0);
    check("t4 no rx", rx_q.size(), 0);

    // Default baud: bit period and frame length at the pin
    tx_data2 = 8'h55;
    tx_valid2 = 1'b1;
    c0 = cyc;
    step();
    tx_valid2 = 1'b0;
    step();
    check("t5 start low", midi_out2, 0);
    n = 0;
    while (midi_out2 == 1'b0 && n < 5000) begin
      step();
      n++;
    end
    check("t5 start bit len", n, 384);
    n = 0;
    while (midi_out2 == 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check("t5 bit0 len", n, 384);
    n = 0;
    while (midi_out2 == 1'b0 && n < 5000) begin
      step();
      n++;
    end
    check("t5 bit1 len", n, 384);
    n = 0;
    while (busy2 && n < 5000) begin
      step();
      n++;
    end
    check("t5 busy low", busy2, 0);
    check("t5 frame len", cyc - c0 - 2, 3840);
    check("t5 idle line", midi_out2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
